// File: rtl/ppu_pkg.sv
// Shared PPU-side constants and the entity slot arbiter state type.
package ppu_pkg;
   localparam int          ENTITY_W     = 18;
   localparam int          NUM_SLOTS    = 15;
   localparam int          VBLANK_LINE  = 480;
   localparam logic [17:0] BLANK_ENTITY = 18'h3F000;

   typedef enum logic {
      ACCEPT = 1'b0,
      COMMIT = 1'b1
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               valid
);
   logic [PTR_W:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
         if (!valid && req[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            valid                 = 1'b1;
         end
      end
   end
endmodule

// File: rtl/entity_slot_arbiter.sv
// Arbitrates game-logic writes into a shadow entity table and copies it to the
// PPU-facing active table once per frame, on the first vblank line.
module entity_slot_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ENTITY_W    = ppu_pkg::ENTITY_W,
   parameter int NUM_SLOTS   = ppu_pkg::NUM_SLOTS,
   parameter int VBLANK_LINE = ppu_pkg::VBLANK_LINE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [4*NUM_REQ-1:0]          slot_idx,
   input  logic [ENTITY_W*NUM_REQ-1:0]   wdata,
   input  logic [9:0]                    counter_V,
   output logic [NUM_REQ-1:0]            ack,
   output logic [NUM_REQ-1:0]            err,
   output logic                          frame_commit,
   output logic [ENTITY_W*NUM_SLOTS-1:0] entity_flat
);
   import ppu_pkg::*;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ENTITY_W-1:0] BLANK = ENTITY_W'(BLANK_ENTITY);

   state_t                state, state_next;
   logic [PTR_W-1:0]      rr_ptr;
   logic [9:0]            counter_v_p1;
   logic [ENTITY_W-1:0]   shadow [NUM_SLOTS];
   logic [ENTITY_W-1:0]   active [NUM_SLOTS];
   logic [NUM_REQ-1:0]    req_eff, grant;
   logic                  grant_vld, vblank_edge, take, win_invalid;
   logic [PTR_W-1:0]      win_idx, ptr_next;
   logic [3:0]            win_slot;
   logic [ENTITY_W-1:0]   win_data;

   assign vblank_edge = (counter_V == 10'(VBLANK_LINE)) && (counter_v_p1 != 10'(VBLANK_LINE));

   // A requester whose ack is showing this cycle is still holding its old
   // request; it only becomes a new request from the next cycle on.
   assign req_eff = req & ~ack;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req   (req_eff),
      .ptr   (rr_ptr),
      .grant (grant),
      .valid (grant_vld)
   );

   always_comb begin
      win_idx  = '0;
      win_slot = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_idx  = PTR_W'(i);
            win_slot = slot_idx[i*4 +: 4];
            win_data = wdata[i*ENTITY_W +: ENTITY_W];
         end
      end
   end

   assign win_invalid = (int'(win_slot) >= NUM_SLOTS);
   assign take        = grant_vld && (state == ACCEPT) && !vblank_edge;
   assign ptr_next    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

   always_comb begin
      state_next = state;
      case (state)
         ACCEPT:  if (vblank_edge) state_next = COMMIT;
         COMMIT:  state_next = ACCEPT;
         default: state_next = ACCEPT;
      endcase
   end

   // Control stage: FSM, pointer, edge history and registered pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ACCEPT;
         rr_ptr       <= '0;
         counter_v_p1 <= '0;
         ack          <= '0;
         err          <= '0;
         frame_commit <= 1'b0;
      end else begin
         state        <= state_next;
         counter_v_p1 <= counter_V;
         ack          <= take ? grant : '0;
         err          <= (take && win_invalid) ? grant : '0;
         frame_commit <= (state == COMMIT);
         if (take) rr_ptr <= ptr_next;
      end
   end

   // Table stage: shadow takes granted writes, active copies shadow on COMMIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            shadow[k] <= BLANK;
            active[k] <= BLANK;
         end
      end else begin
         if (take && !win_invalid) shadow[win_slot] <= win_data;
         if (state == COMMIT) begin
            for (int k = 0; k < NUM_SLOTS; k++) active[k] <= shadow[k];
         end
      end
   end

   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_flat
      assign entity_flat[k*ENTITY_W +: ENTITY_W] = active[k];
   end
endmodule

// File: tb/tb_entity_slot_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a frame-level behavioural model.
module tb_entity_slot_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int ENTITY_W    = 18;
   localparam int NUM_SLOTS   = 15;
   localparam int VBLANK_LINE = 480;
   localparam int FLAT_W      = ENTITY_W * NUM_SLOTS;
   localparam logic [ENTITY_W-1:0] BLANK = 18'h3F000;

   logic                          clk = 1'b0;
   logic                          reset;
   logic [NUM_REQ-1:0]            req;
   logic [4*NUM_REQ-1:0]          slot_idx;
   logic [ENTITY_W*NUM_REQ-1:0]   wdata;
   logic [9:0]                    counter_V;
   logic [NUM_REQ-1:0]            ack;
   logic [NUM_REQ-1:0]            err;
   logic                          frame_commit;
   logic [FLAT_W-1:0]             entity_flat;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [ENTITY_W-1:0] m_shadow [NUM_SLOTS];
   logic [ENTITY_W-1:0] m_active [NUM_SLOTS];
   logic [NUM_REQ-1:0]  m_ack, m_err;
   logic                m_fc;
   bit                  m_commit;
   int                  m_ptr, m_prev;

   always #20 clk = ~clk;

   entity_slot_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .ENTITY_W    (ENTITY_W),
      .NUM_SLOTS   (NUM_SLOTS),
      .VBLANK_LINE (VBLANK_LINE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .slot_idx     (slot_idx),
      .wdata        (wdata),
      .counter_V    (counter_V),
      .ack          (ack),
      .err          (err),
      .frame_commit (frame_commit),
      .entity_flat  (entity_flat)
   );

   task automatic chk(input string name, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [ENTITY_W-1:0] slot_of(input int k);
      return entity_flat[k*ENTITY_W +: ENTITY_W];
   endfunction

   function automatic logic [FLAT_W-1:0] model_flat();
      logic [FLAT_W-1:0] f;
      f = '0;
      for (int k = 0; k < NUM_SLOTS; k++) f[k*ENTITY_W +: ENTITY_W] = m_active[k];
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_SLOTS; k++) begin
         m_shadow[k] = BLANK;
         m_active[k] = BLANK;
      end
      m_ack = '0; m_err = '0; m_fc = 1'b0;
      m_commit = 1'b0; m_ptr = 0; m_prev = 0;
   endtask

   // One clock of the frame-level rules: commit copies shadow, the vblank
   // edge blocks grants, otherwise the next eligible requester from m_ptr wins.
   task automatic model_step();
      logic [NUM_REQ-1:0] nack, nerr;
      bit vedge, commit_now;
      int w, s;
      if (reset) begin
         model_reset();
         return;
      end
      nack = '0; nerr = '0; w = -1;
      commit_now = m_commit;
      vedge = (int'(counter_V) == VBLANK_LINE) && (m_prev != VBLANK_LINE);
      if (commit_now) begin
         for (int k = 0; k < NUM_SLOTS; k++) m_active[k] = m_shadow[k];
      end else if (!vedge) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int c = (m_ptr + k) % NUM_REQ;
            if (w < 0 && req[c] && !m_ack[c]) w = c;
         end
         if (w >= 0) begin
            nack[w] = 1'b1;
            s = int'(slot_idx[w*4 +: 4]);
            if (s == 15) nerr[w] = 1'b1;
            else m_shadow[s] = wdata[w*ENTITY_W +: ENTITY_W];
            m_ptr = (w + 1) % NUM_REQ;
         end
      end
      m_fc     = commit_now;
      m_commit = !commit_now && vedge;
      m_prev   = int'(counter_V);
      m_ack    = nack;
      m_err    = nerr;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("ack",          FLAT_W'(ack),            FLAT_W'(m_ack));
      chk("err",          FLAT_W'(err),            FLAT_W'(m_err));
      chk("frame_commit", FLAT_W'(frame_commit),   FLAT_W'(m_fc));
      chk("entity_flat",  entity_flat,             model_flat());
      chk("ack_onehot0",  FLAT_W'($onehot0(ack)),  FLAT_W'(1));
   endtask

   task automatic set_req(input int i, input logic [3:0] slot, input logic [ENTITY_W-1:0] data);
      req[i] = 1'b1;
      slot_idx[i*4 +: 4] = slot;
      wdata[i*ENTITY_W +: ENTITY_W] = data;
   endtask

   task automatic new_req(input int i);
      logic [3:0] s;
      s = ($urandom_range(7, 0) == 0) ? 4'hF : 4'($urandom_range(14, 0));
      set_req(i, s, ENTITY_W'($urandom));
   endtask

   task automatic drive_random();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && ack[i]) begin
            if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
            else new_req(i);
         end else if (req[i]) begin
            if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
         end else if ($urandom_range(3, 0) == 0) begin
            new_req(i);
         end
      end
      if ($urandom_range(7, 0) != 0) counter_V = (counter_V == 10'd524) ? 10'd0 : counter_V + 10'd1;
   endtask

   initial begin
      int fc_cnt;
      reset = 1'b1; req = '0; slot_idx = '1; wdata = '0; counter_V = '0;
      model_reset();

      // Reset state
      tick();
      chk("rst_ack", FLAT_W'(ack), FLAT_W'(0));
      chk("rst_err", FLAT_W'(err), FLAT_W'(0));
      chk("rst_fc",  FLAT_W'(frame_commit), FLAT_W'(0));
      chk("rst_flat", entity_flat, {NUM_SLOTS{BLANK}});
      tick();
      reset = 1'b0;

      // No requests, one frame to vblank: one commit, table blank
      fc_cnt = 0;
      for (int v = 470; v <= VBLANK_LINE; v++) begin
         counter_V = 10'(v);
         tick();
         fc_cnt += int'(frame_commit);
      end
      repeat (6) begin
         tick();
         fc_cnt += int'(frame_commit);
      end
      chk("idle_commit_count", FLAT_W'(fc_cnt), FLAT_W'(1));
      chk("idle_flat", entity_flat, {NUM_SLOTS{BLANK}});

      // All four requesting from rr_ptr=0: grants 0,1,2,3 back to back
      counter_V = 10'd10;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i), 18'h01000 + ENTITY_W'(i));
      for (int c = 0; c < NUM_REQ; c++) begin
         tick();
         chk("rr_order", FLAT_W'(ack), FLAT_W'(1 << c));
         req = req & ~ack;
      end
      chk("rr_no_midframe_update", entity_flat, {NUM_SLOTS{BLANK}});

      // Requester 2 writes slot 3 mid-frame; visible only from the commit
      counter_V = 10'd100;
      set_req(2, 4'd3, 18'h0A155);
      tick();
      chk("r2_ack", FLAT_W'(ack), FLAT_W'(4'b0100));
      req[2] = 1'b0;
      for (int v = 101; v < VBLANK_LINE; v++) begin
         counter_V = 10'(v);
         tick();
      end
      chk("slot3_before_edge", FLAT_W'(slot_of(3)), FLAT_W'(BLANK));
      counter_V = 10'(VBLANK_LINE);
      tick();
      chk("slot3_edge_cycle", FLAT_W'(slot_of(3)), FLAT_W'(BLANK));
      tick();
      chk("slot3_commit_fc", FLAT_W'(frame_commit), FLAT_W'(1));
      chk("slot3_after_commit", FLAT_W'(slot_of(3)), FLAT_W'(18'h0A155));
      chk("slot0_after_commit", FLAT_W'(slot_of(0)), FLAT_W'(18'h01000));
      fc_cnt = 0;
      repeat (5) begin
         tick();
         fc_cnt += int'(frame_commit);
      end
      chk("held_480_single_commit", FLAT_W'(fc_cnt), FLAT_W'(0));

      // Invalid slot 15 from requester 1: ack and err together
      counter_V = 10'd200;
      set_req(1, 4'hF, 18'h3FFFF);
      tick();
      chk("inv_ack", FLAT_W'(ack), FLAT_W'(4'b0010));
      chk("inv_err", FLAT_W'(err), FLAT_W'(4'b0010));
      req[1] = 1'b0;

      // Request held across the edge: no grant in edge or commit cycle
      counter_V = 10'd479;
      tick();
      counter_V = 10'(VBLANK_LINE);
      set_req(0, 4'd5, 18'h12345);
      tick();
      chk("edge_no_ack", FLAT_W'(ack), FLAT_W'(0));
      tick();
      chk("commit_no_ack", FLAT_W'(ack), FLAT_W'(0));
      chk("commit_fc", FLAT_W'(frame_commit), FLAT_W'(1));
      tick();
      chk("post_commit_ack", FLAT_W'(ack), FLAT_W'(4'b0001));
      req[0] = 1'b0;
      chk("slot5_waits", FLAT_W'(slot_of(5)), FLAT_W'(BLANK));
      counter_V = 10'd0;
      tick();
      counter_V = 10'(VBLANK_LINE);
      tick();
      tick();
      chk("slot5_next_frame", FLAT_W'(slot_of(5)), FLAT_W'(18'h12345));
      chk("slot15_no_write_fc", FLAT_W'(frame_commit), FLAT_W'(1));

      // Reset asserted during COMMIT
      counter_V = 10'd0;
      tick();
      counter_V = 10'(VBLANK_LINE);
      tick();
      set_req(0, 4'd7, 18'h00777);
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_commit_flat", entity_flat, {NUM_SLOTS{BLANK}});
      chk("rst_commit_fc", FLAT_W'(frame_commit), FLAT_W'(0));
      chk("rst_commit_ack", FLAT_W'(ack), FLAT_W'(0));
      tick();
      chk("rst_held_ack", FLAT_W'(ack), FLAT_W'(0));
      reset = 1'b0;
      req = '0;
      counter_V = 10'd0;
      tick();
      counter_V = 10'(VBLANK_LINE);
      tick();
      tick();
      chk("rst_shadow_cleared_fc", FLAT_W'(frame_commit), FLAT_W'(1));
      chk("rst_shadow_cleared", entity_flat, {NUM_SLOTS{BLANK}});

      // Randomized traffic against the model
      counter_V = 10'd300;
      repeat (4000) begin
         drive_random();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
